lfsr_seq_detector: RTL and testbench



---
 rtl/lfsr_seq_detector.sv | 102 ++++++++++
 tb/tb_lfsr_seq_detector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_detector.sv
// Serial pattern detector for the LFSR stimulus stream: counts pattern hits per
// measurement window and records the in-window position of the most recent hit.
module lfsr_seq_detector #(
  parameter int unsigned          PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1011,
  parameter bit                   OVERLAP = 1'b1,
  parameter int unsigned          CNT_W   = 8,
  parameter int unsigned          POS_W   = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             window_tick,
  input  logic             clr,
  output logic             detect,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] window_count,
  output logic             window_valid,
  output logic [POS_W-1:0] last_match_pos
);

  localparam int unsigned          FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [POS_W-1:0]   r_bit_pos;
  logic [CNT_W-1:0]   r_match_cnt;
  logic [CNT_W-1:0]   r_window_count;
  logic [POS_W-1:0]   r_last_match_pos;
  logic               r_detect;
  logic               r_window_valid;

  logic [PAT_LEN-1:0] w_hist_next;
  logic [FILL_W-1:0]  w_fill_next;
  logic               w_match;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Comparator looks at the history as it will be after this edge.
  always_comb begin
    w_hist_next = r_hist;
    w_fill_next = r_fill;
    if (bit_valid) begin
      w_hist_next = {r_hist[PAT_LEN-2:0], bit_in};
      if (r_fill != FILL_FULL) begin
        w_fill_next = r_fill + FILL_W'(1);
      end
    end
    w_match   = bit_valid && (w_fill_next == FILL_FULL) && (w_hist_next == PATTERN);
    w_cnt_inc = r_match_cnt;
    if (w_match && (r_match_cnt != {CNT_W{1'b1}})) begin
      w_cnt_inc = r_match_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist           <= '0;
      r_fill           <= '0;
      r_bit_pos        <= '0;
      r_match_cnt      <= '0;
      r_window_count   <= '0;
      r_last_match_pos <= '0;
      r_detect         <= 1'b0;
      r_window_valid   <= 1'b0;
    end else if (clr) begin
      r_hist         <= '0;
      r_fill         <= '0;
      r_bit_pos      <= '0;
      r_match_cnt    <= '0;
      r_detect       <= 1'b0;
      r_window_valid <= 1'b0;
    end else begin
      r_hist         <= w_hist_next;
      r_fill         <= (w_match && !OVERLAP) ? '0 : w_fill_next;
      r_detect       <= w_match;
      r_window_valid <= window_tick;
      if (w_match) begin
        r_last_match_pos <= r_bit_pos;
      end
      // History survives the window boundary; only the counters restart.
      if (window_tick) begin
        r_window_count <= w_cnt_inc;
        r_match_cnt    <= '0;
        r_bit_pos      <= '0;
      end else begin
        r_match_cnt <= w_cnt_inc;
        if (bit_valid) begin
          r_bit_pos <= r_bit_pos + POS_W'(1);
        end
      end
    end
  end

  assign detect         = r_detect;
  assign match_cnt      = r_match_cnt;
  assign window_count   = r_window_count;
  assign window_valid   = r_window_valid;
  assign last_match_pos = r_last_match_pos;

endmodule

// File: tb/tb_lfsr_seq_detector.sv
// Bench for lfsr_seq_detector: three configurations (overlap, non-overlap, 2-bit
// saturating counter) share one stimulus stream and are compared to a queue-based model.
module tb_lfsr_seq_detector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bit_in = 1'b0, bit_valid = 1'b0, window_tick = 1'b0, clr = 1'b0;

  logic        det0, det1, det2, wv0, wv1, wv2;
  logic [7:0]  mc0, mc1, wc0, wc1;
  logic [1:0]  mc2, wc2;
  logic [23:0] lp0, lp1, lp2;

  always #5 clk = ~clk;

  lfsr_seq_detector #(.OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .window_tick(window_tick), .clr(clr), .detect(det0), .match_cnt(mc0),
    .window_count(wc0), .window_valid(wv0), .last_match_pos(lp0));

  lfsr_seq_detector #(.OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .window_tick(window_tick), .clr(clr), .detect(det1), .match_cnt(mc1),
    .window_count(wc1), .window_valid(wv1), .last_match_pos(lp1));

  lfsr_seq_detector #(.OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .window_tick(window_tick), .clr(clr), .detect(det2), .match_cnt(mc2),
    .window_count(wc2), .window_valid(wv2), .last_match_pos(lp2));

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int dcnt0 = 0, dcnt1 = 0;

  // Model state: recent bits since the last restart, plus per-instance results.
  bit q_ov[$];
  bit q_nov[$];
  int e_cnt[3], e_wc[3], e_lp[3];
  bit e_det[3];
  bit e_wv;
  int e_pos;
  int cmax[3] = '{255, 255, 3};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit ends_pat(input bit q[$]);
    logic [3:0] pat = 4'b1011;
    if (q.size() < 4) return 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (q[q.size() - 4 + k] != pat[3-k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    q_ov.delete();
    q_nov.delete();
    for (int i = 0; i < 3; i++) begin
      e_cnt[i] = 0; e_wc[i] = 0; e_lp[i] = 0; e_det[i] = 1'b0;
    end
    e_wv = 1'b0;
    e_pos = 0;
  endtask

  task automatic model_step();
    bit m[3];
    int nc;
    if (clr) begin
      q_ov.delete();
      q_nov.delete();
      for (int i = 0; i < 3; i++) begin
        e_cnt[i] = 0; e_det[i] = 1'b0;
      end
      e_wv = 1'b0;
      e_pos = 0;
      return;
    end
    m[0] = 1'b0; m[1] = 1'b0;
    if (bit_valid) begin
      q_ov.push_back(bit_in);
      q_nov.push_back(bit_in);
      while (q_ov.size() > 4) void'(q_ov.pop_front());
      while (q_nov.size() > 4) void'(q_nov.pop_front());
      m[0] = ends_pat(q_ov);
      m[1] = ends_pat(q_nov);
      if (m[1]) q_nov.delete();
    end
    m[2] = m[0];
    for (int i = 0; i < 3; i++) begin
      e_det[i] = m[i];
      nc = e_cnt[i] + int'(m[i]);
      if (nc > cmax[i]) nc = cmax[i];
      if (m[i]) e_lp[i] = e_pos;
      if (window_tick) begin
        e_wc[i] = nc;
        e_cnt[i] = 0;
      end else begin
        e_cnt[i] = nc;
      end
    end
    if (window_tick) e_pos = 0;
    else if (bit_valid) e_pos = (e_pos + 1) % (1 << 24);
    e_wv = window_tick;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("detect0", int'(det0), int'(e_det[0]));
      chk("detect1", int'(det1), int'(e_det[1]));
      chk("detect2", int'(det2), int'(e_det[2]));
      chk("match_cnt0", int'(mc0), e_cnt[0]);
      chk("match_cnt1", int'(mc1), e_cnt[1]);
      chk("match_cnt2", int'(mc2), e_cnt[2]);
      chk("window_count0", int'(wc0), e_wc[0]);
      chk("window_count1", int'(wc1), e_wc[1]);
      chk("window_count2", int'(wc2), e_wc[2]);
      chk("window_valid0", int'(wv0), int'(e_wv));
      chk("window_valid1", int'(wv1), int'(e_wv));
      chk("window_valid2", int'(wv2), int'(e_wv));
      chk("last_pos0", int'(lp0), e_lp[0]);
      chk("last_pos1", int'(lp1), e_lp[1]);
      chk("last_pos2", int'(lp2), e_lp[2]);
      if (det0) dcnt0++;
      if (det1) dcnt1++;
    end
  end

  task automatic cyc(input bit b, input bit bv, input bit wt, input bit cl);
    bit_in = b; bit_valid = bv; window_tick = wt; clr = cl;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    bit_valid = 1'b0; window_tick = 1'b0; clr = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_match_cnt", int'(mc0), 0);
    chk("rst_detect", int'(det0), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) cyc(bits[k], 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #1;
    chk_en = 1'b1;
    do_reset();

    // Overlapping vs non-overlapping on 1011011.
    dcnt0 = 0; dcnt1 = 0;
    feed(32'b1011011, 7);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_ov_cnt", int'(mc0), 2);
    chk("t1_ov_pos", int'(lp0), 6);
    chk("t1_ov_detects", dcnt0, 2);
    chk("t1_nov_cnt", int'(mc1), 1);
    chk("t1_nov_detects", dcnt1, 1);
    chk("t1_nov_pos", int'(lp1), 3);

    // Saturation, then close the window.
    do_reset();
    feed(32'b1011011011011011, 16);
    chk("t3_sat_cnt", int'(mc2), 3);
    chk("t3_ov_cnt", int'(mc0), 5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_sat_wc", int'(wc2), 3);
    chk("t3_ov_wc", int'(wc0), 5);
    chk("t3_nov_wc", int'(wc1), 3);
    chk("t3_wv", int'(wv2), 1);
    chk("t3_cnt_clr", int'(mc2), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_wv_once", int'(wv2), 0);

    // Idle cycles interleaved with valid bits.
    do_reset();
    dcnt0 = 0;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] s = 4'b1011;
      cyc(s[3-k], 1'b1, 1'b0, 1'b0);
      if (k == 3) chk("t4_detect", int'(det0), 1);
      cyc(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
    end
    chk("t4_detects", dcnt0, 1);

    // Window closes on the bit that completes the 2nd match; pattern straddles.
    do_reset();
    feed(32'b101101, 6);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_wc", int'(wc0), 2);
    chk("t5_cnt", int'(mc0), 0);
    feed(32'b011, 3);
    chk("t5_new_cnt", int'(mc0), 1);
    chk("t5_new_pos", int'(lp0), 2);

    // Reset mid-pattern discards history.
    do_reset();
    feed(32'b101, 3);
    do_reset();
    dcnt0 = 0;
    feed(32'b1011, 4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_detects", dcnt0, 1);
    chk("t6_pos", int'(lp0), 3);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(999) < 3) do_reset();
      cyc(1'($urandom_range(1)), ($urandom_range(99) < 70), ($urandom_range(99) < 3),
          ($urandom_range(99) < 2));
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
